// File: rtl/snell_quotient_divider.sv
// snell_quotient_divider
//   Sequential restoring divider for the Snell's-law datapath. It produces one
//   quotient bit per clock, MSB first, with a start/busy/done handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       request a division (accepted in IDLE or DONE)
//   dividend    unsigned dividend, sampled with start
//   divisor     unsigned divisor, sampled with start
//   busy        high while iterating
//   done        one-cycle pulse; results valid from this cycle on
//   quotient    floor(dividend / divisor), all ones on divide-by-zero
//   remainder   dividend mod divisor, zero on divide-by-zero
//   div_by_zero set together with done when the latched divisor was 0
module snell_quotient_divider #(
    parameter int unsigned DVD_W = 13,
    parameter int unsigned DVS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(DVD_W);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DVS_W:0]   prem_q, prem_d;
    logic [DVD_W-1:0] q_q, q_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVD_W-1:0] quot_q, quot_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // One restoring step. t carries the whole partial remainder; its top bit is
    // always zero because prem stays below the divisor between steps.
    logic [DVS_W+1:0] t;
    logic [DVS_W:0]   prem_upd;
    logic [DVD_W-1:0] q_upd;

    always_comb begin
        t        = {prem_q, dvd_q[cnt_q]};
        q_upd    = q_q;
        prem_upd = t[DVS_W:0];
        if (t >= {2'b00, dvs_q}) begin
            prem_upd     = (DVS_W+1)'(t - {2'b00, dvs_q});
            q_upd[cnt_q] = 1'b1;
        end else begin
            q_upd[cnt_q] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        q_d     = q_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    prem_d  = '0;
                    q_d     = '0;
                    cnt_d   = CntW'(DVD_W - 1);
                    state_d = StRun;
                    // Divide by zero skips iteration and reports immediately.
                    if (divisor == '0) begin
                        state_d = StDone;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                prem_d = prem_upd;
                q_d    = q_upd;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    quot_d  = q_upd;
                    rem_d   = prem_upd[DVS_W-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prem_q  <= '0;
            q_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            q_q     <= q_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_snell_quotient_divider.sv
module tb_snell_quotient_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] dividend;
    logic [3:0]  divisor;
    logic        busy;
    logic        done;
    logic [12:0] quotient;
    logic [3:0]  remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    snell_quotient_divider #(
        .DVD_W(13),
        .DVS_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, divide-by-zero reported as all ones.
    function automatic void ref_div(input int a, input int b, output int q, output int r,
                                    output int z, output int lat);
        if (b == 0) begin
            q = 13'h1FFF; r = 0; z = 1; lat = 0;
        end else begin
            q = a / b; r = a % b; z = 0; lat = 13;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; counts edges since entry and busy samples seen.
    task automatic wait_done(input int glitch_at, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            start = (lat == glitch_at);
            if (lat == glitch_at) begin
                dividend = 13'($urandom);
                divisor  = 4'($urandom_range(1, 15));
            end
            step();
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic run_div(input string tag, input int a, input int b, input int glitch_at);
        int q, r, z, el, lat, bc;
        ref_div(a, b, q, r, z, el);
        start = 1'b1; dividend = 13'(a); divisor = 4'(b);
        step();
        start = 1'b0;
        dividend = 13'($urandom); divisor = 4'($urandom);
        wait_done(glitch_at, lat, bc);
        check({tag, " done"}, 32'(done), 1);
        check({tag, " latency"}, lat, el);
        check({tag, " busy cycles"}, bc, el);
        check({tag, " quotient"}, 32'(quotient), q);
        check({tag, " remainder"}, 32'(remainder), r);
        check({tag, " div_by_zero"}, 32'(div_by_zero), z);
        step();
        check({tag, " done pulse width"}, 32'(done), 0);
    endtask

    initial begin
        int lat, bc, gap;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step(); step();
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset quotient", 32'(quotient), 0);
        check("reset remainder", 32'(remainder), 0);
        check("reset dbz", 32'(div_by_zero), 0);
        // Reset beats start.
        start = 1'b1; dividend = 13'd100; divisor = 4'd7;
        step();
        check("reset over start busy", 32'(busy), 0);
        rst = 1'b0; start = 1'b0;
        step();

        run_div("7665/15", 7665, 15, -1);
        run_div("100/7", 100, 7, -1);
        run_div("5/9", 5, 9, -1);
        run_div("8191/1", 8191, 1, -1);
        run_div("1234/0", 1234, 0, -1);
        run_div("after dbz 100/7", 100, 7, -1);
        run_div("start while busy", 100, 7, 3);

        // Back-to-back with start held through the done cycle.
        start = 1'b1; dividend = 13'd7665; divisor = 4'd15;
        step();
        dividend = 13'd4000; divisor = 4'd13;
        lat = 0;
        while (!done && lat < 40) begin step(); lat++; end
        check("b2b first done", 32'(done), 1);
        check("b2b first quotient", 32'(quotient), 511);
        check("b2b first remainder", 32'(remainder), 0);
        gap = 0;
        step();
        gap++;
        start = 1'b0;
        dividend = 13'($urandom); divisor = 4'($urandom);
        while (!done && gap < 40) begin step(); gap++; end
        check("b2b second done", 32'(done), 1);
        check("b2b done spacing", gap, 14);
        check("b2b second quotient", 32'(quotient), 307);
        check("b2b second remainder", 32'(remainder), 9);
        step();

        // Reset at the 6th RUN cycle aborts without a done pulse.
        start = 1'b1; dividend = 13'd100; divisor = 4'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("abort still busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort quotient", 32'(quotient), 0);
        check("abort remainder", 32'(remainder), 0);
        check("abort dbz", 32'(div_by_zero), 0);
        rst = 1'b0;
        bc = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) bc++;
            step();
        end
        check("abort no done", bc, 0);
        run_div("post abort 100/7", 100, 7, -1);

        // Randomized operands against the reference.
        for (int i = 0; i < 25; i++) begin
            int a, b;
            a = int'($urandom_range(0, 8191));
            b = (i % 6 == 5) ? 0 : int'($urandom_range(1, 15));
            run_div($sformatf("rand%0d %0d/%0d", i, a, b), a, b, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snell_quotient_divider.md
# snell_quotient_divider

Sequential restoring divider directly downstream of the 9x4 Wallace-tree multiplier in the Snell's-law datapath. It takes the registered 13-bit product n1·sin(θ1) as dividend and the 4-bit refractive index n2 as divisor. It produces sin(θ2) = quotient and remainder, one quotient bit per clock, MSB first. A start/busy/done handshake lets the datapath controller issue back-to-back divisions.

## Interface
- DVD_W, 13, dividend width; matches the multiplier product width.
- DVS_W, 4, divisor width; matches the multiplier's 4-bit operand.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a division; sampled on the rising edge of clk.
- dividend  input  DVD_W  unsigned dividend; sampled with start.
- divisor  input  DVS_W  unsigned divisor; sampled with start.
- busy  output  1  high while iterating (state RUN).
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  DVD_W  unsigned floor(dividend/divisor).
- remainder  output  DVS_W  unsigned dividend mod divisor.
- div_by_zero  output  1  set with done when the latched divisor is 0.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: iterating; counter cnt counts down from DVD_W-1 to 0.
  - DONE: lasts exactly one cycle.
- Start acceptance: start is accepted in IDLE or DONE. In RUN it is ignored, and busy=1 tells the controller so.
- On acceptance:
  - Latch dividend and divisor.
  - Clear the partial remainder prem (DVS_W+1 = 5 bits) and the working quotient.
  - Set cnt=DVD_W-1.
  - If divisor==0, go straight to DONE instead of RUN.
- RUN, each edge:
  - t = {prem[DVS_W-1:0], dvd[cnt]}.
  - If t >= {1'b0, divisor}: prem = t - divisor and q[cnt]=1.
  - Else: prem = t and q[cnt]=0.
  - If cnt==0, go to DONE; otherwise cnt = cnt-1.
- Output updates: quotient, remainder and div_by_zero load only on the edge that enters DONE. They hold their value until the next entry into DONE or until reset.
- Divide by zero: quotient = all ones (13'h1FFF), remainder = 0, div_by_zero = 1.
- Ranges: all arithmetic is unsigned. prem never exceeds 2·divisor−1 ≤ 29, so 5 bits suffice. The remainder always fits in DVS_W bits.
- DONE exit: DONE goes to IDLE unless start is high, in which case it accepts the new operation (back-to-back).

## Timing
- Reset: the state is IDLE. busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, and the internal prem, cnt and q are all 0. Reset takes priority over start and over a division in progress. A reset in RUN aborts the division, and no done pulse follows.
- Latency, nonzero divisor:
  - start is sampled at edge E0.
  - busy=1 from after E0 through edge E13.
  - The 13th iteration happens at edge E13, and done=1 for the cycle between E13 and E14.
  - Latency is 13 cycles.
- Latency, divisor = 0: done=1 for the cycle between E0 and E1. busy stays 0.
- Throughput: if start is held high through the done cycle, the next operation is latched at E14. The next done then comes 13 cycles later, giving a 14-cycle issue interval.
- done is a registered output and equals (state==DONE). busy equals (state==RUN). Neither is combinationally dependent on any input.
- The dividend and divisor inputs may change freely after the accepting edge.

## Test plan
- Maximum product, 7665 / 15 (dividend = 511·15): quotient=511, remainder=0, div_by_zero=0. done goes high 13 cycles after start, and busy is high for exactly 13 cycles.
- Nonzero remainders:
  - 100 / 7: quotient=14, remainder=2.
  - 5 / 9: quotient=0, remainder=5.
  - 8191 / 1: quotient=8191, remainder=0.
- Divisor 0 with dividend 1234: done goes high 1 cycle after start, with quotient=13'h1FFF, remainder=0 and div_by_zero=1. The next valid division clears div_by_zero.
- start pulsed again while busy, with other operands: ignored, and the first result (100/7 → 14 r2) is reported unchanged.
- start held through the done cycle with 7665/15 and then 4000/13: results are 511 r0, then 307 r9, and the two done pulses are 14 cycles apart.
- rst asserted at the 6th RUN cycle: on the next edge everything returns to its reset values, no done pulse appears, and a fresh 100/7 still gives 14 r2.
